fetch_pc_unit: RTL and testbench

Instruction-fetch front end that consumes the branch unit's redirect output (`pc_sel`, `branch_pc`). It owns the program counter, drives the instruction-memory address, and registers the IF/ID pipeline stage. It applies load-use stalls, flushes wrong-path instructions on a taken redirect, and enters a terminal halt state on the halt sentinel target 0xFFFFFFFF.

---
 rtl/fetch_pc_unit_if.sv | 45 ++++
 rtl/fetch_pc_unit.sv | 128 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if
// Bundles the fetch unit's datapath signals between the surrounding pipeline
// (master) and the fetch unit itself (slave).
//   Master -> slave : pc_sel, branch_pc, stall, imem_rdata
//   Slave -> master : imem_addr, if_id_pc, if_id_instr, if_id_valid,
//                     flush_id_ex, halted, misaligned
//                     (+ redirect_count, stall_count when FETCH_STATS_EN)
// Optional feature macro: FETCH_STATS_EN adds the two statistics counters.
interface fetch_pc_unit_if #(
  parameter int WIDTH = 9
);
  logic             pc_sel;
  logic [31:0]      branch_pc;
  logic             stall;
  logic [WIDTH-1:0] imem_addr;
  logic [31:0]      imem_rdata;
  logic [WIDTH-1:0] if_id_pc;
  logic [31:0]      if_id_instr;
  logic             if_id_valid;
  logic             flush_id_ex;
  logic             halted;
  logic             misaligned;
`ifdef FETCH_STATS_EN
  logic [31:0]      redirect_count;
  logic [31:0]      stall_count;
`endif

  modport master (
    output pc_sel, branch_pc, stall, imem_rdata,
    input  imem_addr, if_id_pc, if_id_instr, if_id_valid,
           flush_id_ex, halted, misaligned
`ifdef FETCH_STATS_EN
    , input redirect_count, stall_count
`endif
  );

  modport slave (
    input  pc_sel, branch_pc, stall, imem_rdata,
    output imem_addr, if_id_pc, if_id_instr, if_id_valid,
           flush_id_ex, halted, misaligned
`ifdef FETCH_STATS_EN
    , output redirect_count, stall_count
`endif
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// Instruction-fetch front end: owns the program counter, addresses the
// instruction memory, and registers the IF/ID stage. Handles load-use stalls,
// wrong-path flushes on branch redirects, and a terminal halt triggered by the
// redirect target 0xFFFFFFFF.
// Ports:
//   clk    - system clock, rising-edge
//   reset  - synchronous active-high reset
//   bus    - fetch_pc_unit_if.slave (redirect/stall in, imem address/data,
//            IF/ID outputs, flush, halted, sticky misaligned flag)
// Optional feature macro: FETCH_STATS_EN adds saturating redirect_count and
// stall_count outputs on the interface; without it they do not exist.
module fetch_pc_unit #(
  parameter int WIDTH = 9
) (
  input logic            clk,
  input logic            reset,
  fetch_pc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    RESET_FILL = 2'd0,
    RUN        = 2'd1,
    HALT       = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t           state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] id_pc;
  logic [31:0]      id_instr;
  logic             id_valid;
  logic             halted_q;
  logic             misaligned_q;

  logic             halt_ev;
  logic             redir_ev;
  logic [WIDTH-1:0] target;

  // The full 32-bit target is compared for the sentinel; only the low WIDTH
  // bits (word aligned) become the new PC.
  assign halt_ev  = bus.pc_sel && (bus.branch_pc == 32'hFFFF_FFFF);
  assign redir_ev = bus.pc_sel && !halt_ev;
  assign target   = {bus.branch_pc[WIDTH-1:2], 2'b00};

  assign bus.imem_addr   = pc;
  assign bus.if_id_pc    = id_pc;
  assign bus.if_id_instr = id_instr;
  assign bus.if_id_valid = id_valid;
  assign bus.halted      = halted_q;
  assign bus.misaligned  = misaligned_q;
  // Kills the instruction moving into ID/EX on any redirect, halt included.
  assign bus.flush_id_ex = bus.pc_sel && (state == RUN);

  // RESET_FILL fetches address 0 into IF/ID without advancing the PC, so the
  // first RUN cycle refetches 0 before stepping on.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RESET_FILL;
      pc           <= '0;
      id_pc        <= '0;
      id_instr     <= NOP;
      id_valid     <= 1'b0;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      case (state)
        RESET_FILL: begin
          state    <= RUN;
          id_pc    <= pc;
          id_instr <= bus.imem_rdata;
          id_valid <= 1'b1;
        end
        RUN: begin
          if (halt_ev) begin
            state    <= HALT;
            halted_q <= 1'b1;
            id_valid <= 1'b0;
          end else if (redir_ev) begin
            // Redirect beats stall: the stalled instruction is wrong-path.
            pc       <= target;
            id_valid <= 1'b0;
            if (bus.branch_pc[1:0] != 2'b00) begin
              misaligned_q <= 1'b1;
            end
          end else if (!bus.stall) begin
            pc       <= pc + WIDTH'(4);
            id_pc    <= pc;
            id_instr <= bus.imem_rdata;
            id_valid <= 1'b1;
          end
        end
        HALT: begin
          id_valid <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          state <= RESET_FILL;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] redirect_cnt;
  logic [31:0] stall_cnt;

  assign bus.redirect_count = redirect_cnt;
  assign bus.stall_count    = stall_cnt;

  // Counters only move in RUN and saturate at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else if (state == RUN) begin
      if (redir_ev && (redirect_cnt != 32'hFFFF_FFFF)) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
      if (bus.stall && !bus.pc_sel && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit
// Directed bench for fetch_pc_unit with WIDTH = 9. Memory word k holds k, so
// the fetched instruction always equals its address divided by four.
module tb_fetch_pc_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fetch_pc_unit_if #(.WIDTH(9)) bus ();

  fetch_pc_unit #(.WIDTH(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory: word k = k.
  assign bus.imem_rdata = 32'(bus.imem_addr) >> 2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic checkFetch(input string tag, input logic [31:0] addr,
                            input logic [31:0] id_pc, input logic [31:0] id_instr,
                            input logic valid);
    checkOutput({tag, ".imem_addr"}, 32'(bus.imem_addr), addr);
    checkOutput({tag, ".if_id_pc"}, 32'(bus.if_id_pc), id_pc);
    checkOutput({tag, ".if_id_instr"}, bus.if_id_instr, id_instr);
    checkOutput({tag, ".if_id_valid"}, 32'(bus.if_id_valid), 32'(valid));
  endtask

  task automatic applyStimulus(input logic sel, input logic [31:0] bpc,
                               input logic stl);
    bus.pc_sel    = sel;
    bus.branch_pc = bpc;
    bus.stall     = stl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    tick();

    // Reset state
    checkFetch("reset", 32'h0, 32'h0, 32'h13, 1'b0);
    checkOutput("reset.halted", 32'(bus.halted), 32'h0);
    checkOutput("reset.misaligned", 32'(bus.misaligned), 32'h0);
    checkOutput("reset.flush", 32'(bus.flush_id_ex), 32'h0);

    // Fill cycle then free run
    reset = 1'b0;
    tick();
    checkFetch("fill", 32'h0, 32'h0, 32'h0, 1'b1);
    tick();
    checkFetch("run0", 32'h4, 32'h0, 32'h0, 1'b1);
    tick();
    checkFetch("run1", 32'h8, 32'h4, 32'h1, 1'b1);
    tick();
    checkFetch("run2", 32'hC, 32'h8, 32'h2, 1'b1);
    tick();
    checkFetch("run3", 32'h10, 32'hC, 32'h3, 1'b1);

    // Redirect at PC 0x10 to 0x40
    applyStimulus(1'b1, 32'h40, 1'b0);
    checkOutput("redir.flush", 32'(bus.flush_id_ex), 32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkFetch("redir.n", 32'h40, 32'hC, 32'h3, 1'b0);
    checkOutput("redir.flush_clr", 32'(bus.flush_id_ex), 32'h0);
    tick();
    checkFetch("redir.n1", 32'h44, 32'h40, 32'h10, 1'b1);

    // Position at PC 0x24 with 0x20 in IF/ID, then stall three cycles
    applyStimulus(1'b1, 32'h20, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    checkFetch("prestall", 32'h24, 32'h20, 32'h8, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkFetch("stall", 32'h24, 32'h20, 32'h8, 1'b1);
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    checkFetch("unstall", 32'h28, 32'h24, 32'h9, 1'b1);
`ifdef FETCH_STATS_EN
    checkOutput("stats.stall", bus.stall_count, 32'd3);
`endif

    // Redirect overrides stall
    applyStimulus(1'b1, 32'h8, 1'b1);
    checkOutput("stallredir.flush", 32'(bus.flush_id_ex), 32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkFetch("stallredir", 32'h8, 32'h24, 32'h9, 1'b0);
    tick();
    checkFetch("stallredir.n1", 32'hC, 32'h8, 32'h2, 1'b1);
`ifdef FETCH_STATS_EN
    checkOutput("stats.stall2", bus.stall_count, 32'd3);
    checkOutput("stats.redir3", bus.redirect_count, 32'd3);
`endif

    // Back-to-back redirects, last one wins
    applyStimulus(1'b1, 32'h100, 1'b0);
    tick();
    checkFetch("b2b.first", 32'h100, 32'h8, 32'h2, 1'b0);
    applyStimulus(1'b1, 32'h180, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkFetch("b2b.second", 32'h180, 32'h8, 32'h2, 1'b0);
    tick();
    checkFetch("b2b.land", 32'h184, 32'h180, 32'h60, 1'b1);

    // Misaligned, out-of-range target 0x206 -> PC 0x004
    checkOutput("misal.before", 32'(bus.misaligned), 32'h0);
    applyStimulus(1'b1, 32'h206, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("misal.pc", 32'(bus.imem_addr), 32'h4);
    checkOutput("misal.flag", 32'(bus.misaligned), 32'h1);
    tick();
    checkFetch("misal.n1", 32'h8, 32'h4, 32'h1, 1'b1);
    checkOutput("misal.sticky", 32'(bus.misaligned), 32'h1);

    // Wrap from 0x1FC to 0x000
    applyStimulus(1'b1, 32'h1F8, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    checkFetch("wrap0", 32'h1FC, 32'h1F8, 32'h7E, 1'b1);
    tick();
    checkFetch("wrap1", 32'h0, 32'h1FC, 32'h7F, 1'b1);
    tick();
    checkFetch("wrap2", 32'h4, 32'h0, 32'h0, 1'b1);
`ifdef FETCH_STATS_EN
    checkOutput("stats.redir7", bus.redirect_count, 32'd7);
`endif

    // Halt sentinel
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0);
    checkOutput("halt.flush", 32'(bus.flush_id_ex), 32'h1);
    checkOutput("halt.pre", 32'(bus.halted), 32'h0);
    tick();
    checkOutput("halt.halted", 32'(bus.halted), 32'h1);
    checkFetch("halt", 32'h4, 32'h0, 32'h0, 1'b0);
    checkOutput("halt.misal", 32'(bus.misaligned), 32'h1);
    applyStimulus(1'b1, 32'h40, 1'b1);
    checkOutput("halt.flush_ign", 32'(bus.flush_id_ex), 32'h0);
    tick();
    tick();
    checkFetch("halt.ignore", 32'h4, 32'h0, 32'h0, 1'b0);
    checkOutput("halt.stays", 32'(bus.halted), 32'h1);
`ifdef FETCH_STATS_EN
    checkOutput("stats.redir_frozen", bus.redirect_count, 32'd7);
    checkOutput("stats.stall_frozen", bus.stall_count, 32'd3);
`endif

    // Reset out of HALT
    applyStimulus(1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    tick();
    checkFetch("rehalt", 32'h0, 32'h0, 32'h13, 1'b0);
    checkOutput("rehalt.halted", 32'(bus.halted), 32'h0);
    checkOutput("rehalt.misal", 32'(bus.misaligned), 32'h0);
`ifdef FETCH_STATS_EN
    checkOutput("stats.redir_rst", bus.redirect_count, 32'd0);
`endif
    reset = 1'b0;
    // pc_sel during the fill cycle is ignored and never flushes
    applyStimulus(1'b1, 32'h40, 1'b0);
    checkOutput("fill.flush", 32'(bus.flush_id_ex), 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkFetch("refill", 32'h0, 32'h0, 32'h0, 1'b1);
    tick();
    checkFetch("rerun", 32'h4, 32'h0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
